// File: rtl/mbe_pp_accum_if.sv
// rtl/mbe_pp_accum_if.sv - Booth digit bundle in / signed product out handshake bundle.
// err is present only when MBE_PP_ILLEGAL_CHK_EN is defined.
interface mbe_pp_accum_if #(
   parameter int WIDTH = 8
);
   localparam int NDIG = WIDTH / 2;

   logic                 in_valid;
   logic                 in_ready;
   logic [WIDTH-1:0]     a;
   logic [NDIG-1:0]      single;
   logic [NDIG-1:0]      double;
   logic [NDIG-1:0]      neg;
   logic                 out_valid;
   logic                 out_ready;
   logic [2*WIDTH-1:0]   product;
`ifdef MBE_PP_ILLEGAL_CHK_EN
   logic                 err;

   modport master (
      output in_valid, a, single, double, neg, out_ready,
      input  in_ready, out_valid, product, err
   );
   modport slave (
      input  in_valid, a, single, double, neg, out_ready,
      output in_ready, out_valid, product, err
   );
`else
   modport master (
      output in_valid, a, single, double, neg, out_ready,
      input  in_ready, out_valid, product
   );
   modport slave (
      input  in_valid, a, single, double, neg, out_ready,
      output in_ready, out_valid, product
   );
`endif
endinterface

// File: rtl/mbe_pp_accum.sv
// rtl/mbe_pp_accum.sv - Sequential radix-4 Booth digit decoder/accumulator, one digit per clock.
// Optional illegal-digit (single&double) flag under MBE_PP_ILLEGAL_CHK_EN.
module mbe_pp_accum #(
   parameter int WIDTH = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   mbe_pp_accum_if.slave bus
);
   localparam int NDIG = WIDTH / 2;
   localparam int PW   = 2 * WIDTH;
   localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
   localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t          state;
   logic [CW-1:0]   cnt;
   logic [PW-1:0]   acc;
   logic [WIDTH-1:0] a_r;
   logic [NDIG-1:0] single_r;
   logic [NDIG-1:0] double_r;
   logic [NDIG-1:0] neg_r;
   logic            in_ready_r;
   logic            out_valid_r;

   logic [PW-1:0]   a_ext;
   logic [PW-1:0]   mag;
   logic [PW-1:0]   pp;
   logic [PW-1:0]   pp_shift;

   // Digit k contributes d_k * A * 4^k; double wins over single if both are set.
   always_comb begin
      a_ext    = {{WIDTH{a_r[WIDTH-1]}}, a_r};
      mag      = '0;
      if (double_r[cnt])
         mag = {a_ext[PW-2:0], 1'b0};
      else if (single_r[cnt])
         mag = a_ext;
      pp       = neg_r[cnt] ? (~mag + PW'(1)) : mag;
      pp_shift = pp << {cnt, 1'b0};
   end

`ifdef MBE_PP_ILLEGAL_CHK_EN
   logic err_r;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         cnt         <= '0;
         acc         <= '0;
         a_r         <= '0;
         single_r    <= '0;
         double_r    <= '0;
         neg_r       <= '0;
         in_ready_r  <= 1'b1;
         out_valid_r <= 1'b0;
`ifdef MBE_PP_ILLEGAL_CHK_EN
         err_r       <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  a_r        <= bus.a;
                  single_r   <= bus.single;
                  double_r   <= bus.double;
                  neg_r      <= bus.neg;
                  acc        <= '0;
                  cnt        <= '0;
                  in_ready_r <= 1'b0;
                  state      <= RUN;
               end
            end
            RUN: begin
               acc <= acc + pp_shift;
               cnt <= cnt + CW'(1);
               if (cnt == LAST) begin
                  out_valid_r <= 1'b1;
                  state       <= DONE;
`ifdef MBE_PP_ILLEGAL_CHK_EN
                  // Flag is only presented alongside the product it describes.
                  err_r       <= |(single_r & double_r);
`endif
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  out_valid_r <= 1'b0;
                  in_ready_r  <= 1'b1;
                  state       <= IDLE;
`ifdef MBE_PP_ILLEGAL_CHK_EN
                  err_r       <= 1'b0;
`endif
               end
            end
            default: begin
               in_ready_r  <= 1'b1;
               out_valid_r <= 1'b0;
               state       <= IDLE;
            end
         endcase
      end
   end

   assign bus.in_ready  = in_ready_r;
   assign bus.out_valid = out_valid_r;
   assign bus.product   = acc;
`ifdef MBE_PP_ILLEGAL_CHK_EN
   assign bus.err       = err_r;
`endif
endmodule

// File: tb/tb_mbe_pp_accum.sv
// tb/tb_mbe_pp_accum.sv - Directed and randomized checks of mbe_pp_accum against an arithmetic model.
// Illegal-digit checks are compiled in with MBE_PP_ILLEGAL_CHK_EN.
module tb_mbe_pp_accum;
   localparam int WIDTH = 8;
   localparam int NDIG  = 4;
   localparam int PW    = 16;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   mbe_pp_accum_if #(.WIDTH(WIDTH)) bus ();
   mbe_pp_accum #(.WIDTH(WIDTH)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   int checks   = 0;
   int failures = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Sum of signed digit values times A times 4^k, reduced to the product width.
   function automatic logic [PW-1:0] model(input logic [WIDTH-1:0] av,
                                           input logic [NDIG-1:0] s, input logic [NDIG-1:0] d,
                                           input logic [NDIG-1:0] n);
      longint sum = 0;
      longint as  = longint'($signed(av));
      for (int k = 0; k < NDIG; k++) begin
         longint m = d[k] ? 2 : (s[k] ? 1 : 0);
         if (n[k]) m = -m;
         sum += m * as * (longint'(1) << (2 * k));
      end
      return sum[PW-1:0];
   endfunction

   task automatic booth(input logic [WIDTH-1:0] b, output logic [NDIG-1:0] s,
                        output logic [NDIG-1:0] d, output logic [NDIG-1:0] n);
      for (int k = 0; k < NDIG; k++) begin
         int hi  = int'(b[2*k+1]);
         int mid = int'(b[2*k]);
         int lo  = (k == 0) ? 0 : int'(b[2*k-1]);
         int dig = mid + lo - 2 * hi;
         int mg  = (dig < 0) ? -dig : dig;
         n[k] = (dig < 0);
         s[k] = (mg == 1);
         d[k] = (mg == 2);
      end
   endtask

   task automatic start(input logic [WIDTH-1:0] av, input logic [NDIG-1:0] s,
                        input logic [NDIG-1:0] d, input logic [NDIG-1:0] n);
      int guard = 0;
      while (!bus.in_ready && guard < 50) begin
         @(posedge clk); #1; guard++;
      end
      check("in_ready_wait", 64'(bus.in_ready), 64'd1);
      bus.a = av; bus.single = s; bus.double = d; bus.neg = n; bus.in_valid = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
   endtask

   task automatic wait_valid(input string tag);
      int lat = 0;
      while (!bus.out_valid && lat < 30) begin
         @(posedge clk); #1; lat++;
      end
      check({tag, "_latency"}, 64'(lat), 64'(NDIG));
   endtask

   task automatic accept(input string tag);
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      check({tag, "_in_ready_after"}, 64'(bus.in_ready), 64'd1);
      check({tag, "_out_valid_after"}, 64'(bus.out_valid), 64'd0);
   endtask

   task automatic txn(input string tag, input logic [WIDTH-1:0] av, input logic [NDIG-1:0] s,
                      input logic [NDIG-1:0] d, input logic [NDIG-1:0] n,
                      input logic [PW-1:0] exp);
      start(av, s, d, n);
      wait_valid(tag);
      check({tag, "_product"}, 64'(bus.product), 64'(exp));
`ifdef MBE_PP_ILLEGAL_CHK_EN
      check({tag, "_err"}, 64'(bus.err), 64'(|(s & d)));
`endif
      accept(tag);
   endtask

   initial begin
      logic [WIDTH-1:0] ra, rb;
      logic [NDIG-1:0]  s, d, n;
      logic [PW-1:0]    held;

      bus.in_valid = 1'b0; bus.out_ready = 1'b0;
      bus.a = '0; bus.single = '0; bus.double = '0; bus.neg = '0;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_in_ready", 64'(bus.in_ready), 64'd1);
      check("reset_out_valid", 64'(bus.out_valid), 64'd0);
      check("reset_product", 64'(bus.product), 64'd0);
`ifdef MBE_PP_ILLEGAL_CHK_EN
      check("reset_err", 64'(bus.err), 64'd0);
`endif
      rst_n = 1'b1;
      @(posedge clk); #1;

      txn("t1_3x5", 8'd3, 4'b0011, 4'b0000, 4'b0000, 16'h000F);
      txn("t2_min_x_min", 8'h80, 4'b0000, 4'b1000, 4'b1000, 16'h4000);
      txn("t3_negzero", 8'h7F, 4'b0001, 4'b0000, 4'b1111, 16'hFF81);
      txn("negzero_only", 8'h5A, 4'b0000, 4'b0000, 4'b1111, 16'h0000);

      // Hold the result: product must not move and new inputs must be ignored.
      start(8'd3, 4'b0011, 4'b0000, 4'b0000);
      wait_valid("t4");
      held = bus.product;
      check("t4_product", 64'(held), 64'h000F);
      for (int i = 0; i < 5; i++) begin
         bus.in_valid = 1'b1; bus.a = 8'h55; bus.single = 4'b1111;
         @(posedge clk); #1;
         check("t4_hold_valid", 64'(bus.out_valid), 64'd1);
         check("t4_hold_product", 64'(bus.product), 64'h000F);
         check("t4_hold_in_ready", 64'(bus.in_ready), 64'd0);
      end
      bus.in_valid = 1'b0;
      accept("t4");
      @(posedge clk); #1;
      check("t4_no_restart", 64'(bus.in_ready), 64'd1);

      // Asynchronous abort in the middle of a run.
      start(8'd3, 4'b0011, 4'b0000, 4'b0000);
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      check("t5_rst_out_valid", 64'(bus.out_valid), 64'd0);
      check("t5_rst_in_ready", 64'(bus.in_ready), 64'd1);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      txn("t5_rerun", 8'd3, 4'b0011, 4'b0000, 4'b0000, 16'h000F);

`ifdef MBE_PP_ILLEGAL_CHK_EN
      txn("t6_illegal", 8'd1, 4'b0010, 4'b0010, 4'b0000, 16'h0008);
      txn("t6_legal", 8'd3, 4'b0011, 4'b0000, 4'b0000, 16'h000F);
`endif

      // Randomized multiplier encoded by the bench's own Booth recoding.
      for (int i = 0; i < 16; i++) begin
         logic [PW-1:0] ab;
         ra = 8'($urandom);
         rb = 8'($urandom);
         if (i == 0) begin ra = 8'h80; rb = 8'h80; end
         if (i == 1) begin ra = 8'h7F; rb = 8'h80; end
         booth(rb, s, d, n);
         ab = 16'($signed(ra) * $signed(rb));
         txn("rand_booth", ra, s, d, n, ab);
      end

      // Arbitrary bundles, including illegal single&double and neg-with-zero digits.
      for (int i = 0; i < 16; i++) begin
         ra = 8'($urandom);
         s  = 4'($urandom);
         d  = 4'($urandom);
         n  = 4'($urandom);
         txn("rand_bundle", ra, s, d, n, model(ra, s, d, n));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
